video_hflip_linebuf: RTL and testbench
======================================

VIDEO_HFLIP_LINEBUF -- requirements
Module: video_hflip_linebuf

Interface
REQ-001 Parameter DATA_W, default 8, bits per colour channel.
REQ-002 Parameter NUM_CH, default 3, colour channels per pixel; channel 0 occupies the LSBs.
REQ-003 Parameter MAX_LINE, default 2048, pixel capacity of each line bank; ADDR_W = clog2(MAX_LINE).
REQ-004 pix_1x_clk  in  1  pixel clock; the only clock.
REQ-005 reset_in  in  1  synchronous, active-low reset.
REQ-006 mode_flip  in  1  1 = mirror lines horizontally, 0 = pass lines in order.
REQ-007 de_in, hsync_in, vsync_in  in  1 each  input video timing, qualified by pix_1x_clk.
REQ-008 pix_in  in  NUM_CH*DATA_W  input pixel, valid when de_in=1.
REQ-009 de_out, hsync_out, vsync_out  out  1 each  output timing, equal to the inputs delayed 2 cycles.
REQ-010 pix_out  out  NUM_CH*DATA_W  output pixel, aligned with de_out.
REQ-011 line_len  out  ADDR_W+1  pixel count of the last completed input line.
REQ-012 mode_active  out  1  flip mode latched for the current frame.
REQ-013 overflow  out  1  sticky flag: a line exceeded MAX_LINE.

Function
REQ-014 Two line banks (ping-pong) each hold MAX_LINE pixels; the write bank and the read bank always differ.
REQ-015 The FSM has three states: S_SYNC (after reset), S_PRIME (first active line of a frame), S_RUN.
REQ-016 Rising edge of vsync_in from any state: go to S_PRIME, latch mode_flip into mode_active, clear the read-side stored length to 0.
REQ-017 In S_SYNC, input pixels are ignored and pix_out=0; the timing outputs still propagate.
REQ-018 While de_in=1 in S_PRIME or S_RUN: write pix_in to the write bank at wr_cnt, then increment wr_cnt.
REQ-019 Falling edge of de_in (end of line): line_len<=min(wr_cnt,MAX_LINE); stored length<=same value; swap banks; wr_cnt<=0; S_PRIME->S_RUN.
REQ-020 While de_in=1, rd_cnt increments from 0; read address = stored_len-1-rd_cnt when mode_active=1, rd_cnt when mode_active=0.
REQ-021 Output pixel = read-bank data when rd_cnt<stored_len and the state is S_RUN; otherwise 0.
REQ-022 Latency: de_in -> de_out, sync -> sync_out and read address -> pix_out are all exactly 2 cycles (registered RAM read plus output register).
REQ-023 Net effect: output line k shows input line k-1 (mirrored or not); the first output line of each frame is all zeros.
REQ-024 Input line longer than stored_len: the excess output pixels are 0. Shorter: the output is truncated to the current de_in length.
REQ-025 wr_cnt saturates at MAX_LINE; further pixels on that line are dropped and overflow<=1; overflow is cleared only by reset.
REQ-026 De-assertion of de_in with wr_cnt=0 (glitch) does not swap banks or update line_len.
REQ-027 vsync_in rising in the same cycle as de_in=1: the vsync rule applies first, and the pixel is written as pixel 0 of the S_PRIME line.
REQ-028 mode_flip changes mid-frame have no effect until the next vsync_in rising edge.
REQ-029 Arithmetic is unsigned; the flip address never underflows because flipped reads occur only when rd_cnt<stored_len.

Reset
REQ-030 With reset_in=0 at a clock edge:
  - state<=S_SYNC; wr_cnt, rd_cnt and stored_len <= 0.
  - line_len<=0, mode_active<=0, overflow<=0, bank select<=0.
  - de_out, hsync_out, vsync_out and pix_out <= 0, and the 2-stage pipeline is flushed.
REQ-031 Bank RAM contents are not cleared. A reset mid-line aborts the line, and the block waits for the next vsync_in.

Verification
REQ-032 Parameters DATA_W=8, NUM_CH=3, MAX_LINE=8. Frame: vsync, then line A with pix 1,2,3,4, then line B with pix 5,6,7,8; mode_flip=1 -> B output is 4,3,2,1 and A output is 0,0,0,0; de_out lags de_in by 2 cycles.
REQ-033 Same stimulus with mode_flip=0 -> B output is 1,2,3,4; line_len=4 after each line.
REQ-034 A 10-pixel line with MAX_LINE=8 -> overflow=1, line_len=8; the next line outputs the first 8 stored pixels reversed and then 0,0; overflow stays 1 until reset.
REQ-035 A 4-pixel line followed by a 6-pixel line -> the 6-pixel output is 4,3,2,1,0,0. A 6-pixel line followed by a 3-pixel line (flip) -> output is 6,5,4.
REQ-036 mode_flip toggled mid-frame -> mode_active is unchanged until the next vsync rise and then updates. Simultaneous vsync rise and de_in -> that pixel is stored at address 0.
REQ-037 reset_in=0 asserted for 1 cycle mid-line -> all outputs 0 on the next cycle, data outputs 0 until after a vsync plus one full line, and overflow cleared.

Source files
------------

// File: rtl/video_hflip_linebuf.sv
// Horizontal-flip line buffer. Each input line is written into one of two
// ping-pong banks while the previous line is replayed mirrored or in order.
module video_hflip_linebuf #(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 3,
    parameter int MAX_LINE = 2048,
    localparam int ADDR_W  = $clog2(MAX_LINE),
    localparam int PIX_W   = NUM_CH * DATA_W
) (
    input  logic              pix_1x_clk,
    input  logic              reset_in,
    input  logic              mode_flip,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic [PIX_W-1:0]  pix_out,
    output logic [ADDR_W:0]   line_len,
    output logic              mode_active,
    output logic              overflow
);
    typedef enum logic [1:0] {S_SYNC, S_PRIME, S_RUN} state_t;

    localparam logic [ADDR_W:0] LINE_CAP = (ADDR_W+1)'(MAX_LINE);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_t state, state_next;
    logic accept, rd_enable;
    logic vsync_q, de_q, vsync_rise, line_end;
    logic [ADDR_W:0] wr_cnt, rd_cnt, stored_len;
    logic wr_full, wr_en, rd_valid;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic bank_sel;
    logic [PIX_W-1:0] mem [0:(2<<ADDR_W)-1];
    logic [PIX_W-1:0] rd_data;
    logic de_p, hsync_p, vsync_p, valid_p;

    assign vsync_rise = vsync_in & ~vsync_q;
    // A vsync rise aborts any line ending in the same cycle.
    assign line_end   = ~de_in & de_q & (wr_cnt != '0) & ~vsync_rise;
    assign wr_full    = (wr_cnt == LINE_CAP);

    always_ff @(posedge pix_1x_clk) begin
        if (!reset_in) state <= S_SYNC;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (vsync_rise)
            state_next = S_PRIME;
        else if (state == S_PRIME && line_end)
            state_next = S_RUN;
    end

    always_comb begin
        accept    = vsync_rise || (state != S_SYNC);
        rd_enable = !vsync_rise && (state == S_RUN);
    end

    assign wr_en   = reset_in & de_in & accept & (vsync_rise | ~wr_full);
    assign wr_addr = vsync_rise ? '0 : wr_cnt[ADDR_W-1:0];
    // Modulo-2^ADDR_W arithmetic is exact here because flipped reads are only
    // used while rd_cnt < stored_len <= MAX_LINE.
    assign rd_addr = mode_active
                   ? (stored_len[ADDR_W-1:0] - CNT_ONE[ADDR_W-1:0] - rd_cnt[ADDR_W-1:0])
                   : rd_cnt[ADDR_W-1:0];
    assign rd_valid = de_in & rd_enable & (rd_cnt < stored_len);

    always_ff @(posedge pix_1x_clk) begin
        if (!reset_in) begin
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            stored_len  <= '0;
            line_len    <= '0;
            mode_active <= 1'b0;
            overflow    <= 1'b0;
            bank_sel    <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            de_q    <= de_in;
            if (vsync_rise) begin
                mode_active <= mode_flip;
                stored_len  <= '0;
                wr_cnt      <= de_in ? CNT_ONE : '0;
            end else if (line_end) begin
                line_len   <= wr_cnt;
                stored_len <= wr_cnt;
                bank_sel   <= ~bank_sel;
                wr_cnt     <= '0;
            end else if (de_in && accept) begin
                if (wr_full) overflow <= 1'b1;
                else         wr_cnt   <= wr_cnt + CNT_ONE;
            end
            if (!de_in)
                rd_cnt <= '0;
            else if (rd_cnt != LINE_CAP)
                rd_cnt <= rd_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge pix_1x_clk) begin
        if (wr_en) mem[{bank_sel, wr_addr}] <= pix_in;
        rd_data <= mem[{~bank_sel, rd_addr}];
    end

    always_ff @(posedge pix_1x_clk) begin
        if (!reset_in) begin
            de_p      <= 1'b0;
            hsync_p   <= 1'b0;
            vsync_p   <= 1'b0;
            valid_p   <= 1'b0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            pix_out   <= '0;
        end else begin
            de_p      <= de_in;
            hsync_p   <= hsync_in;
            vsync_p   <= vsync_in;
            valid_p   <= rd_valid;
            de_out    <= de_p;
            hsync_out <= hsync_p;
            vsync_out <= vsync_p;
            pix_out   <= valid_p ? rd_data : '0;
        end
    end
endmodule

// File: tb/tb_video_hflip_linebuf.sv
// Bench for video_hflip_linebuf: a line-level queue model checked every cycle,
// plus directed lines with hand-computed expected pixel sequences.
module tb_video_hflip_linebuf;
    localparam int DATA_W   = 8;
    localparam int NUM_CH   = 3;
    localparam int MAX_LINE = 8;
    localparam int ADDR_W   = 3;
    localparam int PIX_W    = DATA_W * NUM_CH;

    logic clk = 1'b0;
    logic reset_in, mode_flip, de_in, hsync_in, vsync_in;
    logic [PIX_W-1:0] pix_in;
    logic de_out, hsync_out, vsync_out, mode_active, overflow;
    logic [PIX_W-1:0] pix_out;
    logic [ADDR_W:0] line_len;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    logic de_out_q = 1'b0;
    logic [PIX_W-1:0] got[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    video_hflip_linebuf #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_LINE(MAX_LINE)) dut (
        .pix_1x_clk (clk),
        .reset_in   (reset_in),
        .mode_flip  (mode_flip),
        .de_in      (de_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pix_in     (pix_in),
        .de_out     (de_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .pix_out    (pix_out),
        .line_len   (line_len),
        .mode_active(mode_active),
        .overflow   (overflow)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: previous completed line held as a queue, replayed by index.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic [PIX_W-1:0] pix;
    } out_t;

    logic [PIX_W-1:0] prev_line[$];
    logic [PIX_W-1:0] cur_line[$];
    bit   in_frame = 0, m_mode = 0, m_ovf = 0, model_live = 0;
    bit   vs_prev = 0, de_prev = 0;
    int   m_len = 0, run_idx = 0;
    out_t exp_mid = '0, exp_out = '0;

    always @(posedge clk) begin
        out_t now;
        exp_out = exp_mid;
        if (!reset_in) begin
            model_live = 1;
            prev_line.delete();
            cur_line.delete();
            in_frame = 0; m_mode = 0; m_ovf = 0; m_len = 0;
            run_idx = 0; vs_prev = 0; de_prev = 0;
            exp_mid = '0;
            exp_out = '0;
        end else begin
            now.de  = de_in;
            now.hs  = hsync_in;
            now.vs  = vsync_in;
            now.pix = '0;
            if (vsync_in && !vs_prev) begin
                in_frame = 1;
                m_mode   = mode_flip;
                prev_line.delete();
                cur_line.delete();
                if (de_in) cur_line.push_back(pix_in);
            end else if (de_in) begin
                if (run_idx < prev_line.size())
                    now.pix = m_mode ? prev_line[prev_line.size()-1-run_idx] : prev_line[run_idx];
                if (in_frame) begin
                    if (cur_line.size() < MAX_LINE) cur_line.push_back(pix_in);
                    else m_ovf = 1;
                end
            end else if (de_prev && cur_line.size() != 0) begin
                prev_line = cur_line;
                m_len = cur_line.size();
                cur_line.delete();
            end
            run_idx = de_in ? run_idx + 1 : 0;
            vs_prev = vsync_in;
            de_prev = de_in;
            exp_mid = now;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check_output("de_out",      32'(de_out),      32'(exp_out.de));
            check_output("hsync_out",   32'(hsync_out),   32'(exp_out.hs));
            check_output("vsync_out",   32'(vsync_out),   32'(exp_out.vs));
            check_output("pix_out",     32'(pix_out),     32'(exp_out.pix));
            check_output("line_len",    32'(line_len),    32'(m_len));
            check_output("mode_active", 32'(mode_active), 32'(m_mode));
            check_output("overflow",    32'(overflow),    32'(m_ovf));
        end
        if (de_out) got.push_back(pix_out);
        if (de_out && !de_out_q) rise_cyc = cyc;
        de_out_q <= de_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            de_in = 1'b0;
            pix_in = '0;
            tick();
        end
    endtask

    task automatic vsync();
        de_in = 1'b0;
        tick();
        vsync_in = 1'b1;
        tick();
        tick();
        vsync_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic line_tail();
        de_in = 1'b0;
        pix_in = '0;
        hsync_in = 1'b0;
        tick();
        hsync_in = 1'b1;
        tick();
        tick();
        hsync_in = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic send_line(input int n, input int base);
        got.delete();
        for (int i = 0; i < n; i++) begin
            de_in = 1'b1;
            pix_in = PIX_W'(base + i);
            if (i == 0) start_cyc = cyc;
            tick();
        end
        line_tail();
    endtask

    task automatic send_rand_line(input int n, input bit do_reset);
        int k;
        k = $urandom_range(0, n - 1);
        for (int i = 0; i < n; i++) begin
            de_in = 1'b1;
            pix_in = PIX_W'($urandom);
            hsync_in = 1'($urandom_range(0, 1));
            if (do_reset && i == k) reset_in = 1'b0;
            tick();
            reset_in = 1'b1;
        end
        line_tail();
    endtask

    task automatic check_line(input string name, input int n, input int exp_vals[12]);
        check_output({name, " count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check_output(name, (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(exp_vals[i]));
    endtask

    initial begin
        reset_in = 1'b0;
        mode_flip = 1'b0;
        de_in = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        pix_in = '0;
        tick(); tick(); tick();
        check_output("reset de_out",      32'(de_out),      0);
        check_output("reset pix_out",     32'(pix_out),     0);
        check_output("reset line_len",    32'(line_len),    0);
        check_output("reset mode_active", 32'(mode_active), 0);
        check_output("reset overflow",    32'(overflow),    0);
        reset_in = 1'b1;
        idle(2);

        // Flipped frame: first line blank, second line mirrors the first.
        mode_flip = 1'b1;
        vsync();
        send_line(4, 1);
        check_line("flip line A", 4, '{0,0,0,0,0,0,0,0,0,0,0,0});
        check_output("flip line_len A", 32'(line_len), 4);
        send_line(4, 5);
        check_line("flip line B", 4, '{4,3,2,1,0,0,0,0,0,0,0,0});
        check_output("de latency", 32'(rise_cyc - start_cyc), 2);
        check_output("flip mode_active", 32'(mode_active), 1);

        mode_flip = 1'b0;
        vsync();
        send_line(4, 1);
        check_output("pass line_len A", 32'(line_len), 4);
        send_line(4, 5);
        check_line("pass line B", 4, '{1,2,3,4,0,0,0,0,0,0,0,0});
        check_output("pass line_len B", 32'(line_len), 4);

        // Over-long line saturates at 8 pixels and sets the sticky flag.
        mode_flip = 1'b1;
        vsync();
        send_line(10, 1);
        check_output("ovf flag", 32'(overflow), 1);
        check_output("ovf line_len", 32'(line_len), 8);
        send_line(10, 11);
        check_line("ovf replay", 10, '{8,7,6,5,4,3,2,1,0,0,0,0});
        check_output("ovf sticky", 32'(overflow), 1);

        vsync();
        send_line(4, 1);
        send_line(6, 1);
        check_line("short then long", 6, '{4,3,2,1,0,0,0,0,0,0,0,0});
        send_line(3, 20);
        check_line("long then short", 3, '{6,5,4,0,0,0,0,0,0,0,0,0});

        mode_flip = 1'b0;
        idle(2);
        check_output("mode hold idle", 32'(mode_active), 1);
        send_line(2, 1);
        check_output("mode hold line", 32'(mode_active), 1);
        vsync();
        check_output("mode update", 32'(mode_active), 0);

        // vsync rises on the first pixel of a line; that pixel lands at address 0.
        idle(1);
        vsync_in = 1'b1;
        de_in = 1'b1;
        pix_in = 24'h55;
        tick();
        pix_in = 24'h2;
        tick();
        vsync_in = 1'b0;
        pix_in = 24'h3;
        tick();
        line_tail();
        send_line(3, 40);
        check_line("vsync with de", 3, '{85,2,3,0,0,0,0,0,0,0,0,0});

        // One-cycle reset in the middle of a line.
        for (int i = 0; i < 3; i++) begin
            de_in = 1'b1;
            pix_in = PIX_W'(i + 1);
            tick();
        end
        reset_in = 1'b0;
        tick();
        check_output("mid reset de_out",   32'(de_out),   0);
        check_output("mid reset pix_out",  32'(pix_out),  0);
        check_output("mid reset overflow", 32'(overflow), 0);
        check_output("mid reset line_len", 32'(line_len), 0);
        reset_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_in = PIX_W'(i + 4);
            tick();
        end
        line_tail();
        send_line(4, 1);
        check_line("after reset no vsync", 4, '{0,0,0,0,0,0,0,0,0,0,0,0});
        vsync();
        send_line(4, 1);
        check_line("after reset prime", 4, '{0,0,0,0,0,0,0,0,0,0,0,0});
        send_line(4, 9);
        check_line("after reset run", 4, '{1,2,3,4,0,0,0,0,0,0,0,0});

        // Random frames, checked every cycle against the model.
        for (int f = 0; f < 25; f++) begin
            int nl;
            mode_flip = 1'($urandom_range(0, 1));
            vsync();
            nl = $urandom_range(2, 5);
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 3) == 0) mode_flip = ~mode_flip;
                send_rand_line($urandom_range(1, 11), $urandom_range(0, 15) == 0);
                idle($urandom_range(0, 3));
            end
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
